// File: rtl/cmd_reg_timed.sv
// Multi-channel command register with shadow-staged timed commits and a two-stage phase pipeline.
// Optional: define CMD_REG_PHASE_RESET_EN to restart each channel's phase on every freq load.
module cmd_reg_timed #(
  parameter int unsigned N_CHANNELS      = 4,
  parameter int unsigned PHASE_WIDTH     = 14,
  parameter int unsigned FREQ_WIDTH      = 24,
  parameter int unsigned SAMPLES_PER_CLK = 4,
  parameter int unsigned TREF_WIDTH      = 24,
  parameter int unsigned ENV_ADDR_WIDTH  = 12,
  parameter int unsigned CHAN_SEL_WIDTH  = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [TREF_WIDTH-1:0]                tref,
  input  logic [CHAN_SEL_WIDTH-1:0]            chan_sel,
  input  logic [PHASE_WIDTH-1:0]               phase_offs_in,
  input  logic [FREQ_WIDTH-1:0]                freq_in,
  input  logic [ENV_ADDR_WIDTH-1:0]            env_addr_in,
  input  logic [TREF_WIDTH-1:0]                cmd_time,
  input  logic                                 timed,
  input  logic                                 phase_write_en,
  input  logic                                 freq_write_en,
  input  logic                                 env_addr_write_en,
  input  logic                                 cstrobe_in,
  input  logic                                 err_clr,
  output logic [N_CHANNELS*PHASE_WIDTH-1:0]    phase,
  output logic [N_CHANNELS*FREQ_WIDTH-1:0]     freq,
  output logic [N_CHANNELS*ENV_ADDR_WIDTH-1:0] env_addr,
  output logic [N_CHANNELS-1:0]                cstrobe,
  output logic [N_CHANNELS-1:0]                pending,
  output logic [N_CHANNELS-1:0]                overflow_err
);

  localparam int unsigned SpcLog2 = $clog2(SAMPLES_PER_CLK);
  localparam int unsigned AccLsb  = FREQ_WIDTH - PHASE_WIDTH;

  typedef logic [PHASE_WIDTH-1:0]    phase_t;
  typedef logic [FREQ_WIDTH-1:0]     freq_t;
  typedef logic [ENV_ADDR_WIDTH-1:0] env_t;
  typedef logic [TREF_WIDTH-1:0]     tref_t;

  phase_t act_offs_q [N_CHANNELS], act_offs_d [N_CHANNELS];
  freq_t  act_freq_q [N_CHANNELS], act_freq_d [N_CHANNELS];
  env_t   act_env_q  [N_CHANNELS], act_env_d  [N_CHANNELS];

  phase_t     sh_offs_q [N_CHANNELS], sh_offs_d [N_CHANNELS];
  freq_t      sh_freq_q [N_CHANNELS], sh_freq_d [N_CHANNELS];
  env_t       sh_env_q  [N_CHANNELS], sh_env_d  [N_CHANNELS];
  logic [2:0] sh_mask_q [N_CHANNELS], sh_mask_d [N_CHANNELS];
  tref_t      sh_time_q [N_CHANNELS], sh_time_d [N_CHANNELS];

  logic [N_CHANNELS-1:0] sh_strb_q, sh_strb_d;
  logic [N_CHANNELS-1:0] pending_q, pending_d;
  logic [N_CHANNELS-1:0] err_q, err_d;
  logic [N_CHANNELS-1:0] strb_q, strb_d;
  logic [N_CHANNELS-1:0] hit, commit;

  phase_t acc1_q [N_CHANNELS], acc1_d [N_CHANNELS];
  phase_t offs1_q [N_CHANNELS];
  freq_t  freq1_q [N_CHANNELS];
  env_t   env1_q  [N_CHANNELS];
  freq_t  prod    [N_CHANNELS];
  logic [N_CHANNELS-1:0] strb1_q;

  phase_t out_phase_q [N_CHANNELS];
  freq_t  out_freq_q  [N_CHANNELS];
  env_t   out_env_q   [N_CHANNELS];
  logic [N_CHANNELS-1:0] out_strb_q;

`ifdef CMD_REG_PHASE_RESET_EN
  tref_t t0_q [N_CHANNELS], t0_d [N_CHANNELS];
`endif

  logic       cmd_any;
  logic [2:0] wmask;

  assign wmask   = {env_addr_write_en, freq_write_en, phase_write_en};
  assign cmd_any = |wmask | cstrobe_in;

  // Out-of-range chan_sel never matches any channel index, so such commands are dropped.
  always_comb begin
    hit    = '0;
    commit = '0;
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      hit[ch]    = cmd_any && (int'(chan_sel) == ch);
      commit[ch] = pending_q[ch] && (tref == sh_time_q[ch]);
    end
  end

  always_comb begin
    act_offs_d = act_offs_q;
    act_freq_d = act_freq_q;
    act_env_d  = act_env_q;
    sh_offs_d  = sh_offs_q;
    sh_freq_d  = sh_freq_q;
    sh_env_d   = sh_env_q;
    sh_mask_d  = sh_mask_q;
    sh_time_d  = sh_time_q;
    sh_strb_d  = sh_strb_q;
    pending_d  = pending_q;
    err_d      = err_clr ? '0 : err_q;
    strb_d     = '0;
`ifdef CMD_REG_PHASE_RESET_EN
    t0_d = t0_q;
`endif
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      if (commit[ch]) begin
        if (sh_mask_q[ch][0]) act_offs_d[ch] = sh_offs_q[ch];
        if (sh_mask_q[ch][1]) act_freq_d[ch] = sh_freq_q[ch];
        if (sh_mask_q[ch][2]) act_env_d[ch]  = sh_env_q[ch];
        strb_d[ch]    = sh_strb_q[ch];
        pending_d[ch] = 1'b0;
      end
      // Immediate fields land after the commit so they win per field.
      if (hit[ch] && !timed) begin
        if (phase_write_en)    act_offs_d[ch] = phase_offs_in;
        if (freq_write_en)     act_freq_d[ch] = freq_in;
        if (env_addr_write_en) act_env_d[ch]  = env_addr_in;
        strb_d[ch] = strb_d[ch] | cstrobe_in;
      end
      if (hit[ch] && timed) begin
        if (!pending_q[ch] || commit[ch]) begin
          sh_offs_d[ch] = phase_offs_in;
          sh_freq_d[ch] = freq_in;
          sh_env_d[ch]  = env_addr_in;
          sh_mask_d[ch] = wmask;
          sh_strb_d[ch] = cstrobe_in;
          sh_time_d[ch] = cmd_time;
          pending_d[ch] = 1'b1;
        end else begin
          err_d[ch] = 1'b1;
        end
      end
`ifdef CMD_REG_PHASE_RESET_EN
      if ((commit[ch] && sh_mask_q[ch][1]) || (hit[ch] && !timed && freq_write_en)) begin
        t0_d[ch] = tref;
      end
`endif
    end
  end

  // Only the low FREQ_WIDTH product bits can reach the truncated accumulator.
  always_comb begin
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
`ifdef CMD_REG_PHASE_RESET_EN
      prod[ch] = (act_freq_q[ch] * FREQ_WIDTH'(tref_t'(tref - t0_q[ch]))) << SpcLog2;
`else
      prod[ch] = (act_freq_q[ch] * FREQ_WIDTH'(tref)) << SpcLog2;
`endif
      acc1_d[ch] = PHASE_WIDTH'(prod[ch] >> AccLsb);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_strb_q  <= '0;
      pending_q  <= '0;
      err_q      <= '0;
      strb_q     <= '0;
      strb1_q    <= '0;
      out_strb_q <= '0;
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        act_offs_q[ch]  <= '0;
        act_freq_q[ch]  <= '0;
        act_env_q[ch]   <= '0;
        sh_offs_q[ch]   <= '0;
        sh_freq_q[ch]   <= '0;
        sh_env_q[ch]    <= '0;
        sh_mask_q[ch]   <= '0;
        sh_time_q[ch]   <= '0;
        acc1_q[ch]      <= '0;
        offs1_q[ch]     <= '0;
        freq1_q[ch]     <= '0;
        env1_q[ch]      <= '0;
        out_phase_q[ch] <= '0;
        out_freq_q[ch]  <= '0;
        out_env_q[ch]   <= '0;
`ifdef CMD_REG_PHASE_RESET_EN
        t0_q[ch]        <= '0;
`endif
      end
    end else begin
      act_offs_q <= act_offs_d;
      act_freq_q <= act_freq_d;
      act_env_q  <= act_env_d;
      sh_offs_q  <= sh_offs_d;
      sh_freq_q  <= sh_freq_d;
      sh_env_q   <= sh_env_d;
      sh_mask_q  <= sh_mask_d;
      sh_time_q  <= sh_time_d;
      sh_strb_q  <= sh_strb_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      strb_q     <= strb_d;
`ifdef CMD_REG_PHASE_RESET_EN
      t0_q       <= t0_d;
`endif
      acc1_q     <= acc1_d;
      offs1_q    <= act_offs_q;
      freq1_q    <= act_freq_q;
      env1_q     <= act_env_q;
      strb1_q    <= strb_q;
      out_freq_q <= freq1_q;
      out_env_q  <= env1_q;
      out_strb_q <= strb1_q;
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        out_phase_q[ch] <= acc1_q[ch] + offs1_q[ch];
      end
    end
  end

  always_comb begin
    phase    = '0;
    freq     = '0;
    env_addr = '0;
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      phase[ch*PHASE_WIDTH +: PHASE_WIDTH]       = out_phase_q[ch];
      freq[ch*FREQ_WIDTH +: FREQ_WIDTH]          = out_freq_q[ch];
      env_addr[ch*ENV_ADDR_WIDTH +: ENV_ADDR_WIDTH] = out_env_q[ch];
    end
  end

  assign cstrobe      = out_strb_q;
  assign pending      = pending_q;
  assign overflow_err = err_q;

endmodule

// File: tb/tb_cmd_reg_timed.sv
// Scoreboard bench for cmd_reg_timed: pipelined outputs are queued with their due edge.
module tb_cmd_reg_timed;
  localparam int NCH = 4;
  localparam int PW  = 14;
  localparam int FW  = 24;
  localparam int SPC = 4;
  localparam int TW  = 24;
  localparam int EW  = 12;
  localparam int CSW = 2;

  localparam int KPhase = 0;
  localparam int KFreq  = 1;
  localparam int KEnv   = 2;
  localparam int KStrb  = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [TW-1:0] tref;
  logic [CSW-1:0] chan_sel;
  logic [PW-1:0] phase_offs_in;
  logic [FW-1:0] freq_in;
  logic [EW-1:0] env_addr_in;
  logic [TW-1:0] cmd_time;
  logic          timed, phase_write_en, freq_write_en, env_addr_write_en, cstrobe_in, err_clr;

  logic [NCH*PW-1:0] phase;
  logic [NCH*FW-1:0] freq;
  logic [NCH*EW-1:0] env_addr;
  logic [NCH-1:0]    cstrobe, pending, overflow_err;

  logic [3*PW-1:0] phase3;
  logic [3*FW-1:0] freq3;
  logic [3*EW-1:0] env3;
  logic [2:0]      cstrobe3, pending3, err3;

  cmd_reg_timed u_dut (
    .clk(clk), .rstn(rstn), .tref(tref), .chan_sel(chan_sel), .phase_offs_in(phase_offs_in),
    .freq_in(freq_in), .env_addr_in(env_addr_in), .cmd_time(cmd_time), .timed(timed),
    .phase_write_en(phase_write_en), .freq_write_en(freq_write_en),
    .env_addr_write_en(env_addr_write_en), .cstrobe_in(cstrobe_in), .err_clr(err_clr),
    .phase(phase), .freq(freq), .env_addr(env_addr), .cstrobe(cstrobe), .pending(pending),
    .overflow_err(overflow_err)
  );

  // Three-channel copy: chan_sel=3 is out of range here.
  cmd_reg_timed #(.N_CHANNELS(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .tref(tref), .chan_sel(chan_sel), .phase_offs_in(phase_offs_in),
    .freq_in(freq_in), .env_addr_in(env_addr_in), .cmd_time(cmd_time), .timed(timed),
    .phase_write_en(phase_write_en), .freq_write_en(freq_write_en),
    .env_addr_write_en(env_addr_write_en), .cstrobe_in(cstrobe_in), .err_clr(err_clr),
    .phase(phase3), .freq(freq3), .env_addr(env3), .cstrobe(cstrobe3), .pending(pending3),
    .overflow_err(err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    int          ch;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;

  always @(posedge clk) edge_n++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int kind, input int ch);
    case (kind)
      KPhase:  return 32'(phase[ch*PW +: PW]);
      KFreq:   return 32'(freq[ch*FW +: FW]);
      KEnv:    return 32'(env_addr[ch*EW +: EW]);
      default: return 32'(cstrobe[ch]);
    endcase
  endfunction

  function automatic logic [31:0] phase_model(input int unsigned f, input int unsigned t,
                                              input int unsigned offs);
    longint unsigned p;
    p = 64'(f) * 64'(t) * 64'(SPC);
    return 32'(((p >> (FW - PW)) + 64'(offs)) % 64'(1 << PW));
  endfunction

  task automatic expect_at(input int due, input int kind, input int ch, input logic [31:0] exp,
                           input string tag);
    exp_t e;
    e.due = due; e.kind = kind; e.ch = ch; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == edge_n) begin
        check_eq(sb[i].tag, obs(sb[i].kind, sb[i].ch), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic clear_cmd();
    timed = 1'b0; phase_write_en = 1'b0; freq_write_en = 1'b0; env_addr_write_en = 1'b0;
    cstrobe_in = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tref = tref + 1'b1;
    clear_cmd();
  endtask

  task automatic drive(input int ch, input logic t, input logic pwe, input logic fwe,
                       input logic ewe, input logic cs, input int offs, input int f,
                       input int env, input int ctime);
    chan_sel = CSW'(ch); timed = t; phase_write_en = pwe; freq_write_en = fwe;
    env_addr_write_en = ewe; cstrobe_in = cs; phase_offs_in = PW'(offs); freq_in = FW'(f);
    env_addr_in = EW'(env); cmd_time = TW'(ctime);
  endtask

  task automatic check_all_zero(input string pfx);
    for (int ch = 0; ch < NCH; ch++) begin
      check_eq($sformatf("%s_phase%0d", pfx, ch), obs(KPhase, ch), 0);
      check_eq($sformatf("%s_freq%0d", pfx, ch), obs(KFreq, ch), 0);
      check_eq($sformatf("%s_env%0d", pfx, ch), obs(KEnv, ch), 0);
      check_eq($sformatf("%s_strb%0d", pfx, ch), obs(KStrb, ch), 0);
    end
    check_eq({pfx, "_pending"}, 32'(pending), 0);
    check_eq({pfx, "_ovf"}, 32'(overflow_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int e;
    rstn = 1'b0;
    tref = '0;
    clear_cmd();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) begin
      tref = TW'($urandom); chan_sel = CSW'($urandom); phase_offs_in = PW'($urandom);
      freq_in = FW'($urandom); env_addr_in = EW'($urandom); cmd_time = TW'($urandom);
      timed = 1'($urandom); phase_write_en = 1'($urandom); freq_write_en = 1'($urandom);
      env_addr_write_en = 1'($urandom); cstrobe_in = 1'($urandom); err_clr = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check_all_zero("rst");

    rstn = 1'b1;
    clear_cmd();
    tref = '0;
    tick();

    // Channel 3: valid on the 4-channel DUT, out of range on the 3-channel copy.
    drive(3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7, 'h123, 'h055, 0);
    e = edge_n + 1;
    expect_at(e + 2, KFreq, 3, 'h123, "imm3_freq");
    expect_at(e + 2, KEnv, 3, 'h055, "imm3_env");
    expect_at(e + 2, KStrb, 3, 1, "imm3_strb");
    expect_at(e + 3, KStrb, 3, 0, "imm3_strb_end");
    expect_at(e + 2, KPhase, 3, phase_model('h123, 32'(tref) + 1, 7), "imm3_phase");
    repeat (3) tick();
    check_eq("oor_freq3", 32'(|freq3), 0);
    check_eq("oor_env3", 32'(|env3), 0);
    check_eq("oor_phase3", 32'(|phase3), 0);
    check_eq("oor_strb3", 32'(cstrobe3), 0);
    check_eq("oor_pending3", 32'(pending3 | err3), 0);

    // Immediate ch1: tref at stage-1 sample is 5.
    tref = 4;
    drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 100, 'h400, 0, 0);
    e = edge_n + 1;
    expect_at(e + 1, KFreq, 1, 0, "imm1_freq_early");
    expect_at(e + 2, KFreq, 1, 'h400, "imm1_freq");
    expect_at(e + 2, KPhase, 1, 120, "imm1_phase");
    expect_at(e + 2, KFreq, 0, 0, "imm1_other_freq0");
    expect_at(e + 2, KFreq, 2, 0, "imm1_other_freq2");
    expect_at(e + 2, KPhase, 0, 0, "imm1_other_phase0");
    repeat (3) tick();

    // Phase wrap on ch0.
    tref = 0;
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h3FFF, 'h400, 0, 0);
    e = edge_n + 1;
    expect_at(e + 2, KPhase, 0, 'h0003, "wrap_phase");
    repeat (3) tick();

    // Timed ch2 staged at tref=990 for tref=1000.
    tref = 990;
    drive(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 'h0AB, 1000);
    tick();
    check_eq("timed_pending", 32'(pending[2]), 1);
    check_eq("timed_no_ovf", 32'(overflow_err[2]), 0);
    while (tref != 995) tick();
    drive(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 'h0CD, 1002);
    tick();
    check_eq("ovf_set", 32'(overflow_err[2]), 1);
    check_eq("ovf_pending", 32'(pending[2]), 1);
    err_clr = 1'b1;
    tick();
    check_eq("ovf_clr", 32'(overflow_err[2]), 0);
    while (tref != 1000) tick();
    check_eq("pre_commit_pending", 32'(pending[2]), 1);
    // Commit edge, with a new timed command accepted on the same edge.
    drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h100, 0, 1005);
    e = edge_n + 1;
    expect_at(e + 1, KStrb, 2, 0, "commit_strb_early");
    expect_at(e + 2, KStrb, 2, 1, "commit_strb");
    expect_at(e + 3, KStrb, 2, 0, "commit_strb_end");
    expect_at(e + 2, KEnv, 2, 'h0AB, "commit_env");
    tick();
    check_eq("recommit_pending", 32'(pending[2]), 1);
    check_eq("recommit_no_ovf", 32'(overflow_err[2]), 0);
    while (tref != 1005) tick();

    // Commit freq=0x100 collides with immediate freq=0x200.
    drive(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 'h200, 0, 0);
    e = edge_n + 1;
    expect_at(e + 1, KFreq, 2, 0, "coll_freq_early");
    expect_at(e + 2, KFreq, 2, 'h200, "coll_freq");
    expect_at(e + 2, KEnv, 2, 'h0AB, "coll_env");
    expect_at(e + 2, KPhase, 2, phase_model('h200, 1006, 0), "coll_phase");
    tick();
    check_eq("coll_pending", 32'(pending[2]), 0);
    repeat (4) tick();

    // Reset while a command is staged: it must never commit.
    tref = 3000;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 'h1234, 0, 0, 3030);
    tick();
    check_eq("stage_pending", 32'(pending[0]), 1);
    rstn = 1'b0;
    tick();
    check_all_zero("midrst");
    rstn = 1'b1;
    while (tref != 3034) tick();
    check_eq("lost_pending", 32'(pending[0]), 0);
    check_eq("lost_phase0", obs(KPhase, 0), 0);

    check_eq("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
